mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Parametrised memory/IO bus controller between the CPU control unit (MAR/MDR side) and the single-port synchronous RAM, replacing the direct RAM hookup in the CPU top level. It adds:
- a Ready handshake so the control unit can wait out multi-cycle RAM latency;
- a memory-mapped bank of IO_CH input/output ports;
- an unmapped-address error flag.

One controller instance sits inside the CPU top level. Every memory and port access passes through it.

## Interface
Parameters:
- DATA_W, 32, word width
- ADDR_W, 9, word-address width (512-word RAM)
- RAM_LAT, 1, RAM read latency in cycles from address registration to valid RamQ; legal 1..4
- IO_CH, 2, number of memory-mapped port channels; legal 1..8
- IO_BASE, 9'h1F0, first IO word address; IO window is IO_BASE..IO_BASE+15

Ports:
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Read  in  1  read request from control unit (level)
- Write  in  1  write request from control unit (level)
- Addr  in  ADDR_W  access address (MAR)
- WrData  in  DATA_W  write data (MDR)
- RdData  out  DATA_W  read result, held until next completed read
- Ready  out  1  one-cycle completion pulse
- Err  out  1  one-cycle pulse, coincident with Ready, on unmapped IO access or Read&Write both high
- RamAddr  out  ADDR_W  to RAM address
- RamData  out  DATA_W  to RAM data
- RamWren  out  1  to RAM write enable
- RamQ  in  DATA_W  from RAM q
- InPorts  in  IO_CH*DATA_W  external inputs, channel k at bits [k*DATA_W +: DATA_W]
- OutPorts  out  IO_CH*DATA_W  registered output ports, same packing
- OutStrobe  out  IO_CH  one-cycle pulse on the channel just written

## Operation
- FSM states: IDLE, ACCESS, DONE, HOLD.
- IDLE:
  - if Read|Write is sampled high, latch Addr, WrData and op, then go to ACCESS;
  - Read&Write both high executes as a write and sets the pending error.
- Decode of the latched address:
  - Addr < IO_BASE: RAM.
  - IO_BASE ≤ Addr < IO_BASE+IO_CH: port channel Addr-IO_BASE.
  - Remaining IO window and any address above it: unmapped. A read returns 0, a write is dropped, Err is raised.
- ACCESS:
  - Drive RamAddr/RamData from the latches.
  - RamWren = ACCESS & write & RAM target & !Reset.
  - Counter counts RAM_LAT cycles for RAM reads; every other access spends exactly one cycle in ACCESS.
  - On exit:
    - RAM read captures RamQ into RdData.
    - IO read captures the selected InPorts channel.
    - IO write updates the OutPorts channel.
- DONE: Ready=1, Err per latched error, OutStrobe[k]=1 for an IO write to channel k. Next state is HOLD.
- HOLD:
  - Wait until Read and Write are both sampled low, then go to IDLE.
  - This prevents a request held across control-unit T-states from issuing twice.
- RdData is unchanged by writes and by unmapped reads (which load 0).

## Timing
- Acceptance edge E0 (IDLE samples a request).
- Writes (RAM or IO) and IO reads: ACCESS for one cycle, Ready high in the cycle after E1.
- RAM reads: ACCESS for RAM_LAT+1 cycles with RamAddr stable; RdData valid and Ready high in the cycle after E(1+RAM_LAT).
- Fastest back-to-back rate is one access per 4 cycles (writes/IO) and per RAM_LAT+4 cycles (RAM reads). Request release is seen in HOLD.
- Reset values: state IDLE, RdData 0, OutPorts 0, Ready 0, Err 0, OutStrobe 0, RamWren 0.
- Reset mid-access:
  - Abort with no RAM write committed, since RamWren is gated by Reset in the same cycle.
  - No Ready pulse.
  - OutPorts are cleared.
- A request asserted in the Reset cycle is ignored.

## Structure
- Package mem_bus_pkg holds:
  - the state enum (IDLE/ACCESS/DONE/HOLD);
  - the op enum (OP_RD/OP_WR);
  - the target enum (TGT_RAM/TGT_IO/TGT_BAD);
  - a decode function of (addr, IO_BASE, IO_CH).
- Sub-module io_port_bank contains the OutPorts registers, the OutStrobe generation and the InPorts read mux. It is parametrised by DATA_W and IO_CH.
- The FSM, latency counter and RAM drive stay in the top module.

## Test plan
- RAM write then read, RAM_LAT=1: Write Addr=9'h010 data 32'hDEADBEEF → RamWren one cycle, Ready after E1. Read 9'h010 → RdData 32'hDEADBEEF with Ready after E2.
- RAM_LAT=3 read: Ready exactly 4 cycles after acceptance, with RamAddr stable throughout ACCESS.
- IO, IO_CH=2:
  - Write 32'h0000_00A5 to 9'h1F1 → OutPorts[63:32]=32'hA5 and OutStrobe=2'b10 with Ready.
  - Read 9'h1F0 with InPorts[31:0]=32'h1234 → RdData 32'h1234.
- Unmapped 9'h1F5: read → RdData 0, Err=1 with Ready. Write → OutPorts unchanged, Err=1.
- Read held high for 10 cycles → exactly one Ready pulse. Drop Read for one cycle and reassert → second access.
- Reset asserted in the ACCESS cycle of a RAM write to 9'h020 → RamWren 0, no Ready. A later read of 9'h020 returns the previous contents.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and the address decoder for the memory/IO bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
  typedef enum logic [1:0] {TGT_RAM, TGT_IO, TGT_BAD} target_e;

  localparam int DEC_W = 16;

  // Below the IO base is RAM, the first io_ch words of the window are ports,
  // everything from there upward is unmapped.
  function automatic target_e decode(input logic [DEC_W-1:0] addr,
                                     input logic [DEC_W-1:0] io_base,
                                     input logic [DEC_W-1:0] io_ch);
    target_e tgt;
    if (addr < io_base)
      tgt = TGT_RAM;
    else if ((addr - io_base) < io_ch)
      tgt = TGT_IO;
    else
      tgt = TGT_BAD;
    return tgt;
  endfunction

endpackage

// File: rtl/io_port_bank.sv
// Memory-mapped port bank: registered output channels with write strobes,
// plus the input-channel read mux.
module io_port_bank #(
  parameter int DATA_W = 32,
  parameter int IO_CH  = 2,
  parameter int CH_W   = (IO_CH > 1) ? $clog2(IO_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         ch,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [IO_CH*DATA_W-1:0] in_ports,
  output logic [DATA_W-1:0]       rd_data,
  output logic [IO_CH*DATA_W-1:0] out_ports,
  output logic [IO_CH-1:0]        out_strobe
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ports  <= '0;
      out_strobe <= '0;
    end else begin
      out_strobe <= '0;
      for (int k = 0; k < IO_CH; k++) begin
        if (wr_en && ch == CH_W'(k)) begin
          out_ports[k*DATA_W +: DATA_W] <= wr_data;
          out_strobe[k]                 <= 1'b1;
        end
      end
    end
  end

  // NOTE: the default assignment first keeps this mux free of inferred latches.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < IO_CH; k++) begin
      if (ch == CH_W'(k))
        rd_data = in_ports[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus controller between the CPU control unit and the synchronous RAM, with a
// Ready handshake, a memory-mapped port bank and an unmapped-address error.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 9,
  parameter int          RAM_LAT = 1,
  parameter int          IO_CH   = 2,
  parameter int unsigned IO_BASE = 'h1F0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic [DATA_W-1:0]       WrData,
  output logic [DATA_W-1:0]       RdData,
  output logic                    Ready,
  output logic                    Err,
  output logic [ADDR_W-1:0]       RamAddr,
  output logic [DATA_W-1:0]       RamData,
  output logic                    RamWren,
  input  logic [DATA_W-1:0]       RamQ,
  input  logic [IO_CH*DATA_W-1:0] InPorts,
  output logic [IO_CH*DATA_W-1:0] OutPorts,
  output logic [IO_CH-1:0]        OutStrobe
);

  localparam int CH_W  = (IO_CH > 1) ? $clog2(IO_CH) : 1;
  localparam int CNT_W = 3;

  state_e            state_q, state_d;
  op_e               op_q;
  target_e           tgt_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req;
  logic              ram_rd;
  logic              access_exit;
  logic              io_wr;
  logic [CH_W-1:0]   ch_sel;
  logic [DATA_W-1:0] io_rd_data;

  assign req         = Read | Write;
  assign ram_rd      = (op_q == OP_RD) && (tgt_q == TGT_RAM);
  // RAM reads wait out the latency; everything else leaves ACCESS at once.
  assign access_exit = (state_q == ACCESS) && (!ram_rd || cnt_q == CNT_W'(RAM_LAT));
  assign io_wr       = access_exit && (op_q == OP_WR) && (tgt_q == TGT_IO);
  assign ch_sel      = CH_W'(addr_q - ADDR_W'(IO_BASE));

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (access_exit) state_d = DONE;
      DONE:    state_d = HOLD;
      HOLD:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: request latches carry no reset; they are always loaded in IDLE
  // before anything downstream consumes them.
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && req && !Reset) begin
      addr_q  <= Addr;
      wdata_q <= WrData;
      op_q    <= Write ? OP_WR : OP_RD;
      tgt_q   <= decode(DEC_W'(Addr), DEC_W'(IO_BASE), DEC_W'(IO_CH));
      err_q   <= (Read & Write) |
                 (decode(DEC_W'(Addr), DEC_W'(IO_BASE), DEC_W'(IO_CH)) == TGT_BAD);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || state_q != ACCESS) cnt_q <= '0;
    else                            cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_q <= '0;
    end else if (access_exit && op_q == OP_RD) begin
      unique case (tgt_q)
        TGT_RAM: rd_data_q <= RamQ;
        TGT_IO:  rd_data_q <= io_rd_data;
        default: rd_data_q <= '0;
      endcase
    end
  end

  // Gating with Reset keeps an aborted write from reaching the RAM.
  assign RamAddr = addr_q;
  assign RamData = wdata_q;
  assign RamWren = (state_q == ACCESS) && (op_q == OP_WR) && (tgt_q == TGT_RAM) && !Reset;
  assign RdData  = rd_data_q;
  assign Ready   = (state_q == DONE);
  assign Err     = Ready && err_q;

  io_port_bank #(
    .DATA_W (DATA_W),
    .IO_CH  (IO_CH),
    .CH_W   (CH_W)
  ) u_io_port_bank (
    .clk        (Clock),
    .reset      (Reset),
    .wr_en      (io_wr),
    .ch         (ch_sel),
    .wr_data    (wdata_q),
    .in_ports   (InPorts),
    .rd_data    (io_rd_data),
    .out_ports  (OutPorts),
    .out_strobe (OutStrobe)
  );

endmodule
